// File: rtl/frame_tick_receiver.sv
// rtl/frame_tick_receiver.sv - divided-clock frame strobe receiver with handshake and watchdog
// Synchronizes tick_in, emits one tick per accepted rising edge, tracks frames, drops and stalls.
module frame_tick_receiver #(
    parameter int TIMEOUT = 12_000_000,
    parameter int CNT_W   = 24,
    parameter int FRAME_W = 16,
    parameter int MISS_W  = 8
) (
    input  logic               clkin,
    input  logic               reset,
    input  logic               tick_in,
    input  logic               update_ack,
    output logic               tick,
    output logic               update_req,
    output logic [FRAME_W-1:0] frame_count,
    output logic [MISS_W-1:0]  missed_count,
    output logic               stalled
);

    localparam logic ARM_DISARMED = 1'b0;
    localparam logic ARM_ARMED    = 1'b1;
    localparam logic REQ_IDLE     = 1'b0;
    localparam logic REQ_PENDING  = 1'b1;
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    logic               sync1_q, sync1_d;
    logic               sync2_q, sync2_d;
    logic               prev_q, prev_d;
    logic [1:0]         fill_q, fill_d;
    logic               arm_q, arm_d;
    logic               req_q, req_d;
    logic               tick_q, tick_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic [MISS_W-1:0]  miss_q, miss_d;
    logic [CNT_W-1:0]   idle_q, idle_d;
    logic               stalled_q, stalled_d;
    logic               rise;

    always_comb begin
        sync1_d = tick_in;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        // fill tracks when sync2 holds a real sample rather than its reset zero,
        // so a tick_in already high at reset release is never mistaken for an edge
        fill_d  = {fill_q[0], 1'b1};

        arm_d = arm_q;
        if (arm_q == ARM_DISARMED && fill_q[1] && !sync2_q) begin
            arm_d = ARM_ARMED;
        end

        rise   = (arm_q == ARM_ARMED) && sync2_q && !prev_q;
        tick_d = rise;

        req_d  = req_q;
        miss_d = miss_q;
        if (req_q == REQ_IDLE) begin
            if (rise) begin
                req_d = REQ_PENDING;
            end
        end else begin
            if (update_ack && !rise) begin
                req_d = REQ_IDLE;
            end else if (rise && !update_ack && miss_q != '1) begin
                miss_d = miss_q + MISS_W'(1);
            end
        end

        frame_d = frame_q;
        if (rise) begin
            frame_d = frame_q + FRAME_W'(1);
        end

        idle_d = idle_q;
        if (rise) begin
            idle_d = '0;
        end else if (idle_q != TIMEOUT_C) begin
            idle_d = idle_q + CNT_W'(1);
        end

        stalled_d = stalled_q;
        if (rise) begin
            stalled_d = 1'b0;
        end else if (idle_d == TIMEOUT_C) begin
            stalled_d = 1'b1;
        end
    end

    always_ff @(posedge clkin) begin
        if (reset) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            prev_q    <= 1'b0;
            fill_q    <= 2'b00;
            arm_q     <= ARM_DISARMED;
            req_q     <= REQ_IDLE;
            tick_q    <= 1'b0;
            frame_q   <= '0;
            miss_q    <= '0;
            idle_q    <= '0;
            stalled_q <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            prev_q    <= prev_d;
            fill_q    <= fill_d;
            arm_q     <= arm_d;
            req_q     <= req_d;
            tick_q    <= tick_d;
            frame_q   <= frame_d;
            miss_q    <= miss_d;
            idle_q    <= idle_d;
            stalled_q <= stalled_d;
        end
    end

    assign tick         = tick_q;
    assign update_req   = (req_q == REQ_PENDING);
    assign frame_count  = frame_q;
    assign missed_count = miss_q;
    assign stalled      = stalled_q;

endmodule

// File: tb/tb_frame_tick_receiver.sv
// tb/tb_frame_tick_receiver.sv - directed self-checking bench for frame_tick_receiver
module tb_frame_tick_receiver;

    logic       clkin = 1'b0;
    logic       reset = 1'b0;
    logic       tick_in = 1'b0;
    logic       update_ack = 1'b0;
    logic       tick;
    logic       update_req;
    logic [2:0] frame_count;
    logic [1:0] missed_count;
    logic       stalled;

    int checks = 0;
    int failures = 0;

    frame_tick_receiver #(
        .TIMEOUT(20),
        .CNT_W  (24),
        .FRAME_W(3),
        .MISS_W (2)
    ) dut (
        .clkin       (clkin),
        .reset       (reset),
        .tick_in     (tick_in),
        .update_ack  (update_ack),
        .tick        (tick),
        .update_req  (update_req),
        .frame_count (frame_count),
        .missed_count(missed_count),
        .stalled     (stalled)
    );

    always #5 clkin = ~clkin;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clkin);
            #1;
        end
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        cyc(n);
        reset = 1'b0;
    endtask

    // low for 3 cycles, then high; returns just after the edge that makes tick visible
    task automatic make_edge(input logic ack_on_edge);
        tick_in = 1'b0;
        cyc(3);
        tick_in = 1'b1;
        cyc(2);
        update_ack = ack_on_edge;
        cyc(1);
        update_ack = 1'b0;
    endtask

    initial begin
        // reset, then a clean rising edge with exact latency
        do_reset(2);
        check("rst_tick", 32'(tick), 0);
        check("rst_req", 32'(update_req), 0);
        check("rst_frame", 32'(frame_count), 0);
        check("rst_miss", 32'(missed_count), 0);
        check("rst_stalled", 32'(stalled), 0);
        cyc(3);
        tick_in = 1'b1;
        cyc(1);
        check("lat_n", 32'(tick), 0);
        cyc(1);
        check("lat_n1", 32'(tick), 0);
        cyc(1);
        check("lat_n2_tick", 32'(tick), 1);
        check("lat_n2_frame", 32'(frame_count), 1);
        check("lat_n2_req", 32'(update_req), 1);
        cyc(1);
        check("tick_one_cycle", 32'(tick), 0);

        // handshake: ack 4 cycles after the edge
        cyc(2);
        update_ack = 1'b1;
        cyc(1);
        update_ack = 1'b0;
        check("ack_drops_req", 32'(update_req), 0);
        make_edge(1'b0);
        check("edge2_req", 32'(update_req), 1);
        check("edge2_miss", 32'(missed_count), 0);
        tick_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            check("falling_no_tick", 32'(tick), 0);
        end
        make_edge(1'b0);
        check("edge3_miss", 32'(missed_count), 1);
        make_edge(1'b1);
        check("coinc_tick", 32'(tick), 1);
        check("coinc_req", 32'(update_req), 1);
        check("coinc_miss", 32'(missed_count), 1);
        check("coinc_frame", 32'(frame_count), 4);
        make_edge(1'b0);
        check("pre_rst_frame", 32'(frame_count), 5);
        check("pre_rst_req", 32'(update_req), 1);

        // mid-operation reset with tick_in still high
        do_reset(1);
        check("mid_rst_req", 32'(update_req), 0);
        check("mid_rst_frame", 32'(frame_count), 0);
        check("mid_rst_miss", 32'(missed_count), 0);
        for (int i = 0; i < 8; i++) begin
            cyc(1);
            check("mid_rst_no_tick", 32'(tick), 0);
        end
        make_edge(1'b0);
        check("mid_rst_fresh_tick", 32'(tick), 1);
        check("mid_rst_fresh_frame", 32'(frame_count), 1);

        // high during and after reset
        tick_in = 1'b1;
        do_reset(2);
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            check("high_rst_no_tick", 32'(tick), 0);
        end
        check("high_rst_frame", 32'(frame_count), 0);
        make_edge(1'b0);
        check("high_rst_tick", 32'(tick), 1);
        cyc(1);
        check("high_rst_single", 32'(tick), 0);
        check("high_rst_frame1", 32'(frame_count), 1);

        // saturation and wrap
        tick_in = 1'b0;
        do_reset(2);
        for (int i = 0; i < 10; i++) make_edge(1'b0);
        check("sat_miss", 32'(missed_count), 3);
        check("wrap_frame", 32'(frame_count), 2);
        check("sat_req", 32'(update_req), 1);

        // watchdog
        tick_in = 1'b0;
        do_reset(2);
        cyc(19);
        check("wd_19", 32'(stalled), 0);
        cyc(1);
        check("wd_20", 32'(stalled), 1);
        cyc(5);
        check("wd_25", 32'(stalled), 1);
        tick_in = 1'b1;
        cyc(2);
        check("wd_hold", 32'(stalled), 1);
        cyc(1);
        check("wd_clear_tick", 32'(tick), 1);
        check("wd_clear", 32'(stalled), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
